// File: rtl/uart_rx.sv
// 8N1 serial receiver for UART_RXD: mid-bit sampling, valid/ack byte handoff,
// framing-error pulse and sticky overrun flag.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SETTLE  = CW'(2);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          busy_q, busy_d;
   logic          ack;

   always_comb begin
      state_d     = state_q;
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      busy_d      = busy_q;
      ack         = rd_ack & rx_valid_q;

      if (ack) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end

      unique case (state_q)
         WAIT_IDLE: begin
            // The synchroniser resets to idle-high, so let it flush before trusting rx_s.
            if (cnt_q != SETTLE) begin
               cnt_d = cnt_q + CW'(1);
            end else if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  busy_d    = 1'b1;
                  bit_cnt_d = 3'd0;
                  state_d   = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d              = '0;
               shift_d[bit_cnt_q] = rx_s_q;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d  = '0;
               busy_d = 1'b0;
               if (rx_s_q) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  // A coincident ack consumes the old byte: no overrun, flag held.
                  overrun_d  = overrun_q | (rx_valid_q & ~rd_ack);
                  state_d    = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = WAIT_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit with a byte scoreboard.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rd_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int fe_cnt = 0;
   int busy_cnt = 0;
   int val_cnt = 0;
   logic [7:0] exp_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rd_ack   (rd_ack),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (busy) busy_cnt++;
      if (rx_valid) val_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on a falling edge with rx = stop_bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic ack_byte();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!rx_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, rx_valid, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int fe0;
      int v0;
      int b0;

      rx = 1'b1;
      rd_ack = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1: single byte, latency window, ack
      exp_q.push_back(8'h55);
      lat = 0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            @(posedge clk);
            while (!rx_valid && lat < 200) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      check("t1_latency_ok", (lat >= 77 && lat <= 79), 1);
      check("t1_valid", rx_valid, 1);
      check("t1_data", rx_data, exp_q.pop_front());
      check("t1_ovr", overrun, 0);
      check("t1_ferr_cnt", fe_cnt, 0);
      ack_byte();
      check("t1_ack_clear", rx_valid, 0);

      // 2: back-to-back frames, each acked at once
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h0F);
      fork
         begin
            send_frame(8'hA3, 1'b1);
            send_frame(8'h0F, 1'b1);
         end
         begin
            for (int k = 0; k < 2; k++) begin
               wait_valid("t2_valid");
               check("t2_data", rx_data, exp_q.pop_front());
               ack_byte();
               check("t2_ack_clear", rx_valid, 0);
            end
         end
      join
      check("t2_ovr", overrun, 0);
      check("t2_ferr_cnt", fe_cnt, 0);

      // 3: two bytes without ack -> overrun
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1);
      check("t3_ovr_first", overrun, 0);
      send_frame(8'h22, 1'b1);
      check("t3_ovr_set", overrun, 1);
      void'(exp_q.pop_front());
      check("t3_data", rx_data, exp_q.pop_front());
      check("t3_valid", rx_valid, 1);
      ack_byte();
      check("t3_ack_valid", rx_valid, 0);
      check("t3_ack_ovr", overrun, 0);

      // 4: bad stop bit followed by a long break, then a good frame
      fe0 = fe_cnt;
      v0 = val_cnt;
      send_frame(8'hFF, 1'b0);
      repeat (20 * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("t4_ferr_pulses", fe_cnt - fe0, 1);
      check("t4_no_valid", val_cnt - v0, 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      check("t4_valid", rx_valid, 1);
      check("t4_data", rx_data, exp_q.pop_front());
      ack_byte();

      // 5: short glitch on idle line
      fe0 = fe_cnt;
      v0 = val_cnt;
      b0 = busy_cnt;
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("t5_busy", busy_cnt - b0, 0);
      check("t5_valid", val_cnt - v0, 0);
      check("t5_ferr", fe_cnt - fe0, 0);
      exp_q.push_back(8'h96);
      send_frame(8'h96, 1'b1);
      check("t5_after_data", rx_data, exp_q.pop_front());
      ack_byte();

      // 6: reset during data bit 4 of 0x81
      fe0 = fe_cnt;
      v0 = val_cnt;
      fork
         send_frame(8'h81, 1'b1);
         begin
            repeat (44) @(negedge clk);
            check("t6_busy_pre", busy, 1);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check("t6_rst_busy", busy, 0);
            check("t6_rst_data", rx_data, 8'h00);
            check("t6_rst_valid", rx_valid, 0);
            rst = 1'b0;
         end
      join
      repeat (2 * CPB) @(negedge clk);
      check("t6_no_valid", val_cnt - v0, 0);
      check("t6_no_ferr", fe_cnt - fe0, 0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      check("t6_valid", rx_valid, 1);
      check("t6_data", rx_data, exp_q.pop_front());
      ack_byte();
      check("t6_ack_clear", rx_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
